// File: rtl/gpr_mp.sv
// gpr_mp: parameterised multi-port register file for the dual-issue datapath.
// Two write ports (port 1 wins on collision) and NRD combinational read ports.
// Optional hardwired zero entry. A sequential clear engine sweeps one entry per cycle.
// Optional feature macro: GPR_BYPASS_EN (same-cycle write-to-read forwarding).
module gpr_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk_I,
  input  logic                    rst_n_I,
  input  logic [NRD*ADDR_W-1:0]   RA_I,
  output logic [NRD*DATA_W-1:0]   RD_O,
  input  logic                    WE0_I,
  input  logic [ADDR_W-1:0]       WA0_I,
  input  logic [DATA_W-1:0]       WD0_I,
  input  logic                    WE1_I,
  input  logic [ADDR_W-1:0]       WA1_I,
  input  logic [DATA_W-1:0]       WD1_I,
  input  logic                    clr_I,
  output logic                    busy_O
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              busy_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic idle;
  logic wr0;
  logic wr1;

  // Effective write strobes: only in IDLE, not when a clear is starting, never to the zero entry.
  assign idle = (state == ST_IDLE);
  assign wr0  = idle && !clr_I && WE0_I && !((ZERO_REG != 0) && (WA0_I == '0));
  assign wr1  = idle && !clr_I && WE1_I && !((ZERO_REG != 0) && (WA1_I == '0));

  // Next-state logic for the clear engine.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy_O;
    if (state == ST_IDLE) begin
      if (clr_I) begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
        busy_nxt  = 1'b1;
      end
    end else begin
      cnt_nxt = cnt + (ADDR_W + 1)'(1);
      if (cnt == LAST_IDX) begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    end
  end

  // Clear engine state register.
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_O <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_O <= busy_nxt;
    end
  end

  // Storage array: sweep clear during CLEAR, otherwise port 0 then port 1 so port 1 wins.
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_CLEAR) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else begin
      if (wr0) mem[WA0_I] <= WD0_I;
      if (wr1) mem[WA1_I] <= WD1_I;
    end
  end

  // Combinational read ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = RA_I[k*ADDR_W +: ADDR_W];

    // Read mux with optional forwarding; forced to zero while clearing and for the zero entry.
    always_comb begin
      rd = mem[ra];
`ifdef GPR_BYPASS_EN
      if (wr0 && (WA0_I == ra)) rd = WD0_I;
      if (wr1 && (WA1_I == ra)) rd = WD1_I;
`endif
      if (!idle) rd = '0;
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
    end

    assign RD_O[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: scoreboard bench for gpr_mp with default parameters.
// Inputs change just after negedge; outputs are sampled 1ns later, away from posedge.
module tb_gpr_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned DEPTH = 32;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic              we0, we1, clr, busy;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  gpr_mp dut (
    .clk_I(clk), .rst_n_I(rst_n), .RA_I(ra), .RD_O(rd),
    .WE0_I(we0), .WA0_I(wa0), .WD0_I(wd0),
    .WE1_I(we1), .WA1_I(wa1), .WD1_I(wd1),
    .clr_I(clr), .busy_O(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h", tag, obs, exp);
    end
  endtask

  task automatic set_ra(input int port, input int addr);
    ra[port*AW +: AW] = AW'(addr);
  endtask

  // Push the expected value for a port, then pop and compare once the output settles.
  task automatic rd_check(input string tag, input int port, input int addr, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    set_ra(port, addr);
    #1;
    check($sformatf("%s_p%0d_a%0d", tag, port, addr), rd[port*DW +: DW], exp_q.pop_front());
  endtask

  // Present a write for one cycle (caller is just after negedge) and update the model.
  task automatic write2(input logic e0, input int a0, input logic [DW-1:0] d0,
                        input logic e1, input int a1, input logic [DW-1:0] d1);
    we0 = e0; wa0 = AW'(a0); wd0 = d0;
    we1 = e1; wa1 = AW'(a1); wd1 = d1;
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    if (e0 && a0 != 0) model[a0] = d0;
    if (e1 && a1 != 0) model[a1] = d1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Count cycles with busy high, bounded; every cycle both read ports must show 0.
  task automatic sweep(input int inject_wr_at, output int n);
    n = 0;
    while (busy && n < 100) begin
      set_ra(0, (n + 1) % DEPTH);
      set_ra(1, DEPTH - 1);
      clr = (n == 7);
      if (n == inject_wr_at) begin
        we0 = 1'b1; wa0 = AW'(3); wd0 = 32'hA5A5A5A5;
      end else begin
        we0 = 1'b0;
      end
      #1;
      check($sformatf("sweep_rd0_c%0d", n), rd[0 +: DW], 32'h0);
      check($sformatf("sweep_rd1_c%0d", n), rd[DW +: DW], 32'h0);
      n++;
      @(negedge clk);
    end
    clr = 1'b0; we0 = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] bp;
    rst_n = 1'b0; ra = '0; clr = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    model_clear();

    // 1. reset then read
    #2;
    check("busy_in_reset", 32'(busy), 32'h0);
    rd_check("rd_in_reset", 0, 13, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("busy_after_reset", 32'(busy), 32'h0);
    for (int a = 0; a < DEPTH; a++) begin
      rd_check("reset", 0, a, 32'h0);
      rd_check("reset", 1, DEPTH - 1 - a, 32'h0);
    end

    // 2. single write / read
    write2(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0);
    rd_check("wr5", 0, 5, model[5]);
    rd_check("wr5_exp", 0, 5, 32'hDEADBEEF);
    rd_check("wr6", 1, 6, 32'h0);

    // 3. collision and zero register
    write2(1'b1, 9, 32'h11111111, 1'b1, 9, 32'h22222222);
    rd_check("collide", 0, 9, 32'h22222222);
    rd_check("collide", 1, 9, model[9]);
    write2(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 32'hFFFFFFFF);
    rd_check("zero_reg", 0, 0, 32'h0);
    rd_check("zero_reg", 1, 0, 32'h0);
    write2(1'b1, 12, 32'h0000_00C0, 1'b1, 13, 32'h0000_00D0);
    rd_check("dual", 0, 12, 32'h0000_00C0);
    rd_check("dual", 1, 13, 32'h0000_00D0);

    // 4. clear sweep with a dropped write
    for (int i = 1; i < DEPTH; i++) write2(1'b1, i, DW'(i), 1'b0, 0, 32'h0);
    for (int a = 0; a < DEPTH; a++) rd_check("preload", a % 2, a, DW'(a));
    clr = 1'b1;
    we1 = 1'b1; wa1 = AW'(4); wd1 = 32'hBAD0BAD0;
    @(negedge clk);
    clr = 1'b0; we1 = 1'b0;
    check("busy_rise", 32'(busy), 32'h1);
    sweep(5, n);
    model_clear();
    check("busy_cycles", 32'(n), 32'd32);
    check("busy_fall", 32'(busy), 32'h0);
    for (int a = 0; a < DEPTH; a++) rd_check("post_clear", a % 2, a, model[a]);

    // 5. reset mid-clear, then a full restart
    write2(1'b1, 7, 32'h77777777, 1'b1, 20, 32'h20202020);
    rd_check("pre_abort", 0, 20, 32'h20202020);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int c = 0; c < 10; c++) @(negedge clk);
    check("busy_sweep10", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("busy_abort", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) rd_check("post_abort", (a + 1) % 2, a, model[a]);
    write2(1'b1, 30, 32'h30303030, 1'b0, 0, 32'h0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sweep(-1, n);
    model_clear();
    check("restart_cycles", 32'(n), 32'd32);
    rd_check("restart_clear", 0, 30, model[30]);

    // 6. bypass
    write2(1'b1, 7, 32'hCAFEF00D, 1'b0, 0, 32'h0);
    we1 = 1'b1; wa1 = AW'(7); wd1 = 32'h12345678;
`ifdef GPR_BYPASS_EN
    bp = 32'h12345678;
`else
    bp = 32'hCAFEF00D;
`endif
    rd_check("bypass_same_cycle", 0, 7, bp);
    @(negedge clk);
    we1 = 1'b0;
    model[7] = 32'h12345678;
    rd_check("bypass_after", 0, 7, model[7]);
    we0 = 1'b1; wa0 = AW'(8); wd0 = 32'h08080808;
    we1 = 1'b1; wa1 = AW'(8); wd1 = 32'h18181818;
`ifdef GPR_BYPASS_EN
    bp = 32'h18181818;
`else
    bp = 32'h0;
`endif
    rd_check("bypass_prio", 1, 8, bp);
    wa0 = AW'(0); wd0 = 32'hFFFFFFFF;
    rd_check("bypass_zero", 0, 0, 32'h0);
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    model[8] = 32'h18181818;
    rd_check("prio_after", 1, 8, model[8]);
    rd_check("zero_after", 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
Parametrised multi-port general-purpose register file. It is the next-generation replacement for the single-write, two-read GPR in the MIPS datapath and targets the dual-issue pipeline. It adds:
- configurable width, depth and read-port count
- two write ports with defined priority
- a hardwired zero register
- a multi-cycle sequential clear engine with a busy flag
- optional same-cycle write-to-read bypass

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk_I  in  1  single clock; all state updates on posedge
rst_n_I  in  1  asynchronous active-low reset
RA_I  in  NRD*ADDR_W  read addresses, flattened; port k uses bits [k*ADDR_W +: ADDR_W]
RD_O  out  NRD*DATA_W  read data, flattened the same way; combinational
WE0_I  in  1  write enable, port 0
WA0_I  in  ADDR_W  write address, port 0
WD0_I  in  DATA_W  write data, port 0
WE1_I  in  1  write enable, port 1 (higher priority)
WA1_I  in  ADDR_W  write address, port 1
WD1_I  in  DATA_W  write data, port 1
clr_I  in  1  synchronous pulse that starts the sequential clear
busy_O  out  1  high while the clear engine runs

Behaviour:
- Reset: rst_n_I low asynchronously zeroes all entries and the clear counter, and drives state to IDLE and busy_O to 0. RD_O reads 0 during reset. Reset asserted mid-clear aborts the clear; the array is zeroed anyway.
- Reads: RD_O port k = entry[RA_k], combinational, zero latency. With ZERO_REG=1, address 0 always returns 0.
- Writes: take effect at posedge when WEn_I=1 and state is IDLE; the new value is visible on RD_O after that edge.
  - Both ports writing the same address: WD1_I wins and WD0_I is dropped.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Clear engine, states IDLE and CLEAR:
  - IDLE -> CLEAR at posedge when clr_I=1; counter loads 0 and busy_O rises the same edge.
  - In CLEAR, each posedge zeroes entry[counter] and increments counter.
  - After the edge that clears entry 2**ADDR_W-1, state returns to IDLE and busy_O falls. busy_O is therefore high for exactly 2**ADDR_W cycles.
  - Counter is ADDR_W+1 bits wide so the last entry does not wrap prematurely.
- Interactions with CLEAR:
  - Writes presented on either port are ignored (not queued); the producer must stall on busy_O.
  - RD_O is forced to 0 on all ports, including entries not yet swept.
  - clr_I is ignored; the sweep does not restart.
- clr_I and a write in the same IDLE cycle: clear wins and the write is dropped.

Optional Feature:
Macro GPR_BYPASS_EN.
- Defined: in IDLE, if read port k address matches an enabled write address (not a discarded zero-register write), RD_O port k returns the incoming write data in the same cycle. Port 1 data takes priority over port 0 when both match. This restores the write-then-read-in-one-cycle property the old design obtained by negedge writes.
- Undefined: no bypass; RD_O shows the old value until after the write edge.

Test Plan:
1. Reset then read: drive rst_n_I=0 and release; all RA ports at addresses 0..31 -> RD_O = 0x00000000 everywhere, busy_O=0.
2. Single write/read: WE0=1, WA0=5, WD0=0xDEADBEEF at one edge; next cycle RA port0=5 -> 0xDEADBEEF, port1=6 -> 0.
3. Dual-write collision: WA0=WA1=9, WD0=0x11111111, WD1=0x22222222 -> entry 9 reads 0x22222222. Writing 0xFFFFFFFF to address 0 with ZERO_REG=1 -> reads 0.
4. Clear sweep: preload entries 1..31 with their index, pulse clr_I -> busy_O high exactly 32 cycles, RD_O=0 throughout. A write of 0xA5A5A5A5 to address 3 mid-sweep is dropped; after busy_O falls all entries read 0.
5. Reset mid-clear: assert rst_n_I=0 at sweep cycle 10 -> busy_O=0 immediately and all entries read 0 after release. A new clr_I restarts the full 32-cycle sweep.
6. Bypass: WE1=1, WA1=7, WD1=0x12345678 with RA port0=7 in the same cycle -> RD_O port0 = 0x12345678 before the edge when GPR_BYPASS_EN is defined, and the old value of entry 7 when it is not.
